// File: rtl/data_memory.sv
// data_memory
//   Byte-addressable scratch memory with big-endian 32-bit word access.
//   A word at byte address A occupies mem[A] (bits 31:24) through mem[A+3]
//   (bits 7:0). Only the low ADDR_LSBS address bits select a byte, so the
//   address space aliases modulo MEM_BYTES, and the three trailing bytes of a
//   word wrap around the top of the array. Any byte alignment is legal.
//
// Ports
//   clk        rising-edge clock for all state changes
//   rst_n      synchronous active-low clear of every byte (wins over writes)
//   Address    byte address of the word's most-significant byte
//   Writedata  word stored on the next rising edge when MemWrite=1
//   MemWrite   write enable
//   MemRead    read enable; Readdata is forced to zero when low
//   Readdata   combinational read of the addressed word

module data_memory #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_LSBS = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] Writedata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Readdata
);

    localparam logic [ADDR_LSBS-1:0] OFS_1 = ADDR_LSBS'(1);
    localparam logic [ADDR_LSBS-1:0] OFS_2 = ADDR_LSBS'(2);
    localparam logic [ADDR_LSBS-1:0] OFS_3 = ADDR_LSBS'(3);

    logic [7:0] mem_q [MEM_BYTES];
    logic [7:0] mem_d [MEM_BYTES];

    // Byte indices for the four bytes of the word. The additions are done at
    // index width so that carries out of the top bit drop, giving the
    // modulo-MEM_BYTES wrap for free.
    logic [ADDR_LSBS-1:0] idx_0;
    logic [ADDR_LSBS-1:0] idx_1;
    logic [ADDR_LSBS-1:0] idx_2;
    logic [ADDR_LSBS-1:0] idx_3;

    // Upper address bits intentionally do not participate (aliasing).
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_LSBS];

    assign idx_0 = Address[ADDR_LSBS-1:0];
    assign idx_1 = idx_0 + OFS_1;
    assign idx_2 = idx_0 + OFS_2;
    assign idx_3 = idx_0 + OFS_3;

    always_comb begin
        mem_d = mem_q;
        if (MemWrite) begin
            mem_d[idx_0] = Writedata[31:24];
            mem_d[idx_1] = Writedata[23:16];
            mem_d[idx_2] = Writedata[15:8];
            mem_d[idx_3] = Writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: 8'h00};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read path taps the stored bytes directly, so during a write cycle it
    // shows the old word until the edge commits the new one.
    assign Readdata = MemRead ? {mem_q[idx_0], mem_q[idx_1], mem_q[idx_2], mem_q[idx_3]}
                              : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// traffic compared against a byte-array reference model.

module tb_data_memory;

    localparam int MB = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] Writedata;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Readdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [MB];

    data_memory #(.MEM_BYTES(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Address   (Address),
        .Writedata (Writedata),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Readdata  (Readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
        int unsigned base;
        if (!re) return 32'h0;
        base = a % MB;
        return {ref_mem[base], ref_mem[(base + 1) % MB],
                ref_mem[(base + 2) % MB], ref_mem[(base + 3) % MB]};
    endfunction

    task automatic model_edge(input logic rst, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        int unsigned base;
        if (!rst) begin
            for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
        end else if (we) begin
            base = a % MB;
            for (int k = 0; k < 4; k++)
                ref_mem[(base + k) % MB] = d[31 - 8*k -: 8];
        end
    endtask

    // One clock cycle with the given inputs: Readdata is checked against the
    // model just before and just after the rising edge.
    task automatic cycle(input string tag, input logic rst, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        rst_n = rst; MemWrite = we; MemRead = re; Address = a; Writedata = d;
        #1;
        check_eq({tag, "_pre"}, Readdata, model_read(a, re));
        @(posedge clk);
        model_edge(rst, we, a, d);
        #1;
        check_eq({tag, "_post"}, Readdata, model_read(a, re));
        MemWrite = 1'b0;
        rst_n = 1'b1;
    endtask

    // Combinational read between edges against a fixed expected word.
    task automatic peek(input string tag, input logic [31:0] a, input logic re,
                        input logic [31:0] exp);
        @(negedge clk);
        MemWrite = 1'b0; rst_n = 1'b1; MemRead = re; Address = a;
        #1;
        check_eq(tag, Readdata, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        r, w, rd;

        rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; Address = '0; Writedata = '0;
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'hxx;

        // Reset: pre-edge contents are unknown, so just clock it in.
        @(posedge clk);
        model_edge(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        peek("rst_a0",   32'h0000_0000, 1'b1, 32'h0);
        peek("rst_a100", 32'h0000_0064, 1'b1, 32'h0);
        peek("rst_a255", 32'h0000_00FF, 1'b1, 32'h0);

        // First edge after reset release writes immediately.
        @(negedge clk);
        cycle("w9999", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_270F);
        peek("rd_off_9999", 32'h0, 1'b0, 32'h0);
        peek("rd_9999",     32'h0, 1'b1, 32'h0000_270F);
        peek("rd_9999_a1",  32'h1, 1'b1, 32'h0027_0F00);

        cycle("w7777", 1'b1, 1'b1, 1'b0, 32'h4, 32'h0000_1E61);
        peek("rd_7777", 32'h4, 1'b1, 32'h0000_1E61);
        peek("rd_9999_again", 32'h0, 1'b1, 32'h0000_270F);

        // Simultaneous read/write: old word before the edge, new after.
        @(negedge clk);
        rst_n = 1'b1; MemWrite = 1'b1; MemRead = 1'b1; Address = 32'h4; Writedata = 32'h1;
        #1;
        check_eq("rw_before", Readdata, 32'h0000_1E61);
        @(posedge clk);
        model_edge(1'b1, 1'b1, 32'h4, 32'h1);
        #1;
        check_eq("rw_after", Readdata, 32'h0000_0001);
        MemWrite = 1'b0;

        // Reset beats a write in the same cycle and wipes earlier data.
        @(negedge clk);
        cycle("rst_prio", 1'b0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);
        peek("rst_prio_a8", 32'h8, 1'b1, 32'h0);
        peek("rst_prio_a0", 32'h0, 1'b1, 32'h0);
        peek("rst_prio_a4", 32'h4, 1'b1, 32'h0);

        // Unaligned write straddling the top of the array.
        @(negedge clk);
        cycle("wrap_w", 1'b1, 1'b1, 1'b0, MB - 2, 32'hAABB_CCDD);
        peek("wrap_a0",   32'h0,    1'b1, 32'hCCDD_0000);
        peek("wrap_a254", MB - 2,   1'b1, 32'hAABB_CCDD);
        peek("wrap_a255", MB - 1,   1'b1, 32'hBBCC_DD00);

        // Aliasing: 0x100 maps onto byte 0.
        @(negedge clk);
        cycle("alias_w", 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678);
        peek("alias_a0",  32'h0000_0000, 1'b1, 32'h1234_5678);
        peek("alias_hi",  32'hFFFF_FF00, 1'b1, 32'h1234_5678);
        peek("alias_254", 32'h0000_00FE, 1'b1, 32'hAABB_1234);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            r  = ($urandom_range(0, 39) != 0);
            w  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = {$urandom_range(0, 255) << 8} | (32'(MB) - 32'($urandom_range(1, 4)));
                default: a = 32'($urandom_range(0, 15));
            endcase
            d = $urandom;
            @(negedge clk);
            cycle("rand", r, w, rd, a, d);
            a = $urandom;
            peek("rand_peek", a, 1'b1, model_read(a, 1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: MEM_BYTES, default 256, storage depth in bytes; SHALL be a power of two, minimum 4.
REQ-002 Parameter: ADDR_LSBS, default log2(MEM_BYTES) = 8, number of low Address bits used as the byte index.
REQ-003 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low; acts only on a rising clk edge while low.
REQ-005 Port: Address  input  32  byte address of the word's most-significant byte.
REQ-006 Port: Writedata  input  32  word to store when MemWrite=1.
REQ-007 Port: MemWrite  input  1  write enable, 1 = store Writedata at the next rising edge.
REQ-008 Port: MemRead  input  1  read enable, 1 = drive the addressed word on Readdata.
REQ-009 Port: Readdata  output  32  word read from memory.

Function
REQ-010 Storage SHALL be a byte array mem[0..MEM_BYTES-1], 8 bits per entry, byte-addressable.
REQ-011 Word layout SHALL be big-endian: mem[A] = bits 31:24, mem[A+1] = 23:16, mem[A+2] = 15:8, mem[A+3] = 7:0.
REQ-012 Byte index SHALL be Address[ADDR_LSBS-1:0]; upper Address bits are ignored, so accesses alias modulo MEM_BYTES.
REQ-013 Byte offsets A+1..A+3 SHALL wrap modulo MEM_BYTES; for example, A = MEM_BYTES-2 touches bytes MEM_BYTES-2, MEM_BYTES-1, 0, 1.
REQ-014 Unaligned addresses SHALL be fully supported, with no alignment fault or trap.
REQ-015 Write: on a rising edge with rst_n=1 and MemWrite=1, all four bytes SHALL be updated simultaneously; write latency is 1 edge.
REQ-016 With MemWrite=0, memory contents SHALL hold unchanged.
REQ-017 Read SHALL be combinational, with zero latency: MemRead=1 drives Readdata = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
REQ-018 With MemRead=0, Readdata SHALL be 32'h0000_0000.
REQ-019 With MemRead=1 and MemWrite=1 together, Readdata SHALL show the pre-edge contents until the edge, then the newly written word.
REQ-020 Readdata SHALL follow Address and content changes within the same cycle, with no registered output stage.
REQ-021 The block SHALL contain no handshake and no state machine; it is a pure storage element.

Reset
REQ-022 On a rising edge with rst_n=0, every mem byte SHALL be cleared to 8'h00.
REQ-023 Reset SHALL take priority over MemWrite; a write requested in a reset cycle is discarded.
REQ-024 During and after reset, with MemRead=1, Readdata SHALL be 32'h0 for any address until a subsequent write.
REQ-025 Deasserting rst_n SHALL need no recovery cycles; a write on the first edge with rst_n=1 SHALL take effect.
REQ-026 Asserting reset in the middle of a sequence of writes SHALL clear all earlier writes.

Verification
REQ-027 Write 9999 then read:
- Stimulus: reset, then Address=0, Writedata=9999 (32'h0000270F), MemWrite=1, MemRead=0 for one edge.
- Required memory: mem[0..3] = 00, 00, 27, 0F.
- Required read: Readdata = 0 while MemRead=0, and 9999 once MemRead=1, MemWrite=0.
REQ-028 Second word, no overlap:
- Stimulus: Address=4, Writedata=7777 (32'h00001E61), MemWrite=1, then read Address=4 and Address=0.
- Required response: 7777 at Address=4 and 9999 at Address=0, each with no cycle of latency.
REQ-029 Unaligned and wrap write:
- Stimulus: write 32'hAABBCCDD at Address=MEM_BYTES-2.
- Required memory: mem[254]=AA, mem[255]=BB, mem[0]=CC, mem[1]=DD.
- Required read: Address=0 returns 32'hCCDD0000 when the 9999 word was cleared first by reset.
REQ-030 Aliasing: write 32'h12345678 at Address=32'h0000_0100 -> read at Address=0 returns 32'h12345678.
REQ-031 Reset priority: rst_n=0 with MemWrite=1, Address=8, Writedata=32'hFFFFFFFF for one edge -> read at Address=8 returns 32'h0, and all earlier data reads 0.
REQ-032 Simultaneous read and write: MemRead=1 and MemWrite=1 at Address=4 with new data 32'h0000_0001 -> Readdata = 7777 before the edge and 1 after it.
